// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side SD CMD line responder: receives 48-bit commands, answers after NCR cycles
// Optional macro SD_RESP_CRC_CHECK_EN: when defined, commands whose CRC7 mismatches are dropped.
module sd_cmd_responder #(
  parameter int NCR = 2
) (
  input  logic        sd_clk_i,
  input  logic        rst_n_i,
  input  logic        sd_cmd_dat_i,
  output logic        sd_cmd_out_o,
  output logic        sd_cmd_oe_o,
  input  logic [31:0] card_status_i,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        crc_err_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, RECV, CHECK, WAIT, SEND} state_t;

  localparam logic [5:0] LP_WAIT = 6'(NCR - 2);

  state_t      r_state, w_state_n;
  logic [5:0]  r_cnt, w_cnt_n;
  logic [47:0] r_rx, w_rx_n;
  logic [47:0] r_tx, w_tx_n;
  logic [6:0]  r_crc, w_crc_n;
  logic        r_out, w_out_n;
  logic        r_oe, w_oe_n;
  logic        r_valid, w_valid_n;
  logic        r_crc_err, w_crc_err_n;
  logic        r_frame_err, w_frame_err_n;
  logic [5:0]  r_index, w_index_n;
  logic [31:0] r_arg, w_arg_n;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  logic       w_frame_ok;
  logic       w_crc_ok;
  logic [5:0] w_rx_index;
  logic [5:0] w_resp_index;
  logic [6:0] w_resp_crc;
  logic       w_unused;

  assign w_rx_index = r_rx[45:40];
  assign w_frame_ok = r_rx[46] & r_rx[0];
`ifdef SD_RESP_CRC_CHECK_EN
  assign w_crc_ok = (r_rx[7:1] == r_crc);
`else
  assign w_crc_ok = 1'b1;
`endif
  assign w_unused = ^{r_rx[47], r_rx[7:1], r_crc};

  // R3 carries no meaningful index or CRC; both fields are sent as all ones
  assign w_resp_index = (w_rx_index == 6'd41) ? 6'h3F : w_rx_index;
  assign w_resp_crc   = (w_rx_index == 6'd41) ? 7'h7F
                                              : crc7_40({2'b00, w_rx_index, card_status_i});

  always_ff @(posedge sd_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:  if (!sd_cmd_dat_i) w_state_n = RECV;
      RECV:  if (r_cnt == 6'd47) w_state_n = CHECK;
      CHECK: begin
        if (!w_frame_ok || !w_crc_ok || w_rx_index == 6'd0) w_state_n = IDLE;
        else                                                 w_state_n = WAIT;
      end
      WAIT:  if (r_cnt == 6'd0) w_state_n = SEND;
      SEND:  if (r_cnt == 6'd48) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_n       = r_cnt;
    w_rx_n        = r_rx;
    w_tx_n        = r_tx;
    w_crc_n       = r_crc;
    w_out_n       = r_out;
    w_oe_n        = r_oe;
    w_valid_n     = 1'b0;
    w_crc_err_n   = 1'b0;
    w_frame_err_n = 1'b0;
    w_index_n     = r_index;
    w_arg_n       = r_arg;
    case (r_state)
      IDLE: begin
        w_out_n = 1'b1;
        w_oe_n  = 1'b0;
        w_crc_n = 7'd0;
        if (!sd_cmd_dat_i) begin
          w_rx_n  = {r_rx[46:0], sd_cmd_dat_i};
          w_cnt_n = 6'd1;
        end
      end
      RECV: begin
        w_rx_n  = {r_rx[46:0], sd_cmd_dat_i};
        w_cnt_n = r_cnt + 6'd1;
        if (r_cnt < 6'd40) w_crc_n = crc7_step(r_crc, sd_cmd_dat_i);
      end
      CHECK: begin
        if (!w_frame_ok)    w_frame_err_n = 1'b1;
        else if (!w_crc_ok) w_crc_err_n   = 1'b1;
        else begin
          w_valid_n = 1'b1;
          w_index_n = w_rx_index;
          w_arg_n   = r_rx[39:8];
          w_tx_n    = {2'b00, w_resp_index, card_status_i, w_resp_crc, 1'b1};
          w_cnt_n   = LP_WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 6'd0) begin
          w_out_n = r_tx[47];
          w_oe_n  = 1'b1;
          w_tx_n  = {r_tx[46:0], 1'b0};
          w_cnt_n = 6'd1;
        end else begin
          w_cnt_n = r_cnt - 6'd1;
        end
      end
      SEND: begin
        if (r_cnt == 6'd48) begin
          w_out_n = 1'b1;
          w_oe_n  = 1'b0;
        end else begin
          w_out_n = r_tx[47];
          w_tx_n  = {r_tx[46:0], 1'b0};
          w_cnt_n = r_cnt + 6'd1;
        end
      end
      default: begin
        w_out_n = 1'b1;
        w_oe_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sd_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt       <= 6'd0;
      r_rx        <= 48'd0;
      r_tx        <= 48'd0;
      r_crc       <= 7'd0;
      r_out       <= 1'b1;
      r_oe        <= 1'b0;
      r_valid     <= 1'b0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_index     <= 6'd0;
      r_arg       <= 32'd0;
    end else begin
      r_cnt       <= w_cnt_n;
      r_rx        <= w_rx_n;
      r_tx        <= w_tx_n;
      r_crc       <= w_crc_n;
      r_out       <= w_out_n;
      r_oe        <= w_oe_n;
      r_valid     <= w_valid_n;
      r_crc_err   <= w_crc_err_n;
      r_frame_err <= w_frame_err_n;
      r_index     <= w_index_n;
      r_arg       <= w_arg_n;
    end
  end

  assign sd_cmd_out_o = r_out;
  assign sd_cmd_oe_o  = r_oe;
  assign cmd_valid_o  = r_valid;
  assign cmd_index_o  = r_index;
  assign cmd_arg_o    = r_arg;
  assign crc_err_o    = r_crc_err;
  assign frame_err_o  = r_frame_err;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb/tb_sd_cmd_responder.sv - directed self-checking bench for sd_cmd_responder (NCR=2 and NCR=5 instances)
module tb_sd_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b1;
  logic [31:0] status = 32'd0;
  logic        out2, oe2, valid2, cerr2, ferr2, busy2;
  logic [5:0]  idx2;
  logic [31:0] arg2;
  logic        out5, oe5, valid5, cerr5, ferr5, busy5;
  logic [5:0]  idx5;
  logic [31:0] arg5;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sd_cmd_responder #(.NCR(2)) dut (
    .sd_clk_i(clk), .rst_n_i(rst_n), .sd_cmd_dat_i(din),
    .sd_cmd_out_o(out2), .sd_cmd_oe_o(oe2), .card_status_i(status),
    .cmd_valid_o(valid2), .cmd_index_o(idx2), .cmd_arg_o(arg2),
    .crc_err_o(cerr2), .frame_err_o(ferr2), .busy_o(busy2)
  );

  sd_cmd_responder #(.NCR(5)) dut5 (
    .sd_clk_i(clk), .rst_n_i(rst_n), .sd_cmd_dat_i(din),
    .sd_cmd_out_o(out5), .sd_cmd_oe_o(oe5), .card_status_i(status),
    .cmd_valid_o(valid5), .cmd_index_o(idx5), .cmd_arg_o(arg5),
    .crc_err_o(cerr5), .frame_err_o(ferr5), .busy_o(busy5)
  );

  // CRC7 as the remainder of d * x^7 divided by x^7+x^3+1 (0x89)
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] ix, input logic [31:0] a,
                                         input logic [6:0] c, input logic t, input logic e);
    return {1'b0, t, ix, a, c, e};
  endfunction

  function automatic logic [47:0] mk_resp(input logic [5:0] ix, input logic [31:0] s);
    return {2'b00, ix, s, ref_crc7({2'b00, ix, s}), 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [47:0] f);
    repeat (2) @(negedge clk);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      din = f[i];
    end
    @(negedge clk);
    din = 1'b1;
  endtask

  // Observes 66 cycles after the end bit: n counts negedges after edge E
  task automatic run_cmd(input logic [47:0] f, output int lat, output int lat5,
                         output logic [47:0] resp, output logic drop_ok, output logic v1,
                         output int nvalid, output int ncerr, output int nferr);
    lat = -1; lat5 = -1; resp = '0; drop_ok = 1'b0; v1 = 1'b0;
    nvalid = 0; ncerr = 0; nferr = 0;
    send_cmd(f);
    for (int n = 1; n <= 66; n++) begin
      @(negedge clk);
      if (n == 1) v1 = valid2;
      if (valid2) nvalid++;
      if (cerr2) ncerr++;
      if (ferr2) nferr++;
      if (oe2 && lat < 0) lat = n;
      if (oe5 && lat5 < 0) lat5 = n;
      if (lat >= 0 && n - lat < 48) resp = {resp[46:0], out2};
      if (lat >= 0 && n == lat + 48) drop_ok = !oe2 && out2;
    end
  endtask

  int          lat, lat5, nvalid, ncerr, nferr;
  logic [47:0] resp;
  logic        drop_ok, v1;
  logic [47:0] cmd8;

  initial begin
    cmd8 = mk_cmd(6'd8, 32'h000001AA, 7'h43, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_oe", oe2, 0);
    chk("rst_out", out2, 1);
    chk("rst_valid", valid2, 0);
    chk("rst_index", idx2, 0);
    chk("rst_arg", arg2, 0);
    chk("rst_crc_err", cerr2, 0);
    chk("rst_frame_err", ferr2, 0);
    chk("rst_busy", busy2, 0);
    rst_n = 1'b1;

    status = 32'h00000120;
    run_cmd(cmd8, lat, lat5, resp, drop_ok, v1, nvalid, ncerr, nferr);
    chk("cmd8_valid_e1", v1, 1);
    chk("cmd8_valid_once", nvalid, 1);
    chk("cmd8_index", idx2, 8);
    chk("cmd8_arg", arg2, 32'h000001AA);
    chk("cmd8_latency", lat, 2);
    chk("cmd8_resp", resp, mk_resp(6'd8, 32'h00000120));
    chk("cmd8_release", drop_ok, 1);
    chk("cmd8_busy_after", busy2, 0);

    run_cmd(mk_cmd(6'd0, 32'd0, 7'h4A, 1'b1, 1'b1), lat, lat5, resp, drop_ok, v1, nvalid, ncerr, nferr);
    chk("cmd0_valid_e1", v1, 1);
    chk("cmd0_index", idx2, 0);
    chk("cmd0_arg", arg2, 0);
    chk("cmd0_no_resp", lat, -1);

    status = 32'h80FF8000;
    run_cmd(mk_cmd(6'd41, 32'h40FF8000, ref_crc7({2'b01, 6'd41, 32'h40FF8000}), 1'b1, 1'b1),
            lat, lat5, resp, drop_ok, v1, nvalid, ncerr, nferr);
    chk("cmd41_index", idx2, 41);
    chk("cmd41_arg", arg2, 32'h40FF8000);
    chk("cmd41_latency", lat, 2);
    chk("cmd41_resp", resp, 48'h3F80FF8000FF);

    status = 32'h00000120;
    run_cmd(mk_cmd(6'd8, 32'h000001AA, 7'h42, 1'b1, 1'b1), lat, lat5, resp, drop_ok, v1, nvalid, ncerr, nferr);
`ifdef SD_RESP_CRC_CHECK_EN
    chk("badcrc_crc_err", ncerr, 1);
    chk("badcrc_no_valid", nvalid, 0);
    chk("badcrc_no_resp", lat, -1);
    chk("badcrc_index_held", idx2, 41);
`else
    chk("badcrc_no_crc_err", ncerr, 0);
    chk("badcrc_valid", nvalid, 1);
    chk("badcrc_latency", lat, 2);
    chk("badcrc_resp", resp, mk_resp(6'd8, 32'h00000120));
`endif

    run_cmd(mk_cmd(6'd8, 32'h000001AA, 7'h43, 1'b0, 1'b1), lat, lat5, resp, drop_ok, v1, nvalid, ncerr, nferr);
    chk("trans0_frame_err", nferr, 1);
    chk("trans0_no_valid", nvalid, 0);
    chk("trans0_no_resp", lat, -1);

    run_cmd(mk_cmd(6'd8, 32'h000001AA, 7'h43, 1'b1, 1'b0), lat, lat5, resp, drop_ok, v1, nvalid, ncerr, nferr);
    chk("end0_frame_err", nferr, 1);
    chk("end0_no_valid", nvalid, 0);
    chk("end0_no_resp", lat, -1);

    run_cmd(mk_cmd(6'd8, 32'h00000155, ref_crc7({2'b01, 6'd8, 32'h00000155}), 1'b1, 1'b1),
            lat, lat5, resp, drop_ok, v1, nvalid, ncerr, nferr);
    chk("after_err_valid", v1, 1);
    chk("after_err_arg", arg2, 32'h00000155);
    chk("after_err_resp", resp, mk_resp(6'd8, 32'h00000120));

    send_cmd(cmd8);
    for (int n = 0; n < 10 && !oe2; n++) @(negedge clk);
    chk("rst_test_resp_started", oe2, 1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midsend_rst_oe", oe2, 0);
    chk("midsend_rst_out", out2, 1);
    chk("midsend_rst_busy", busy2, 0);
    chk("midsend_rst_index", idx2, 0);
    chk("midsend_rst_arg", arg2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(cmd8, lat, lat5, resp, drop_ok, v1, nvalid, ncerr, nferr);
    chk("post_rst_index", idx2, 8);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_resp", resp, mk_resp(6'd8, 32'h00000120));
    chk("ncr5_latency", lat5, 5);
    chk("ncr5_index", idx5, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
